// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side control logic.
package fifo_ctrl_pkg;

  // Two-state arbiter FSM: waiting for a requester, or serving one burst.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Width needed to index n items; never less than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', with wrap.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Walk distances from far to near so the nearest requester after 'last' wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Handshake: producer i's word is taken in the cycle where grant[i] & req[i];
// write_en/data_in carry that same word to the FIFO, which captures it at the
// next clk edge. grant is withheld combinationally while fifo_full is high.
// The FSM state is visible on busy (busy == XFER).
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic                       fifo_full,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       write_en,
  output logic [WIDTH-1:0]           data_in,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [CNT_W-1:0]           wr_count
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int BC_W = id_w(MAX_BURST);
  localparam logic [BC_W-1:0] BURST_END = BC_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [BC_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [WIDTH-1:0] word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign word[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, grant and write-port mux; an exit always hands priority onward.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    count_d = count_q;
    grant   = '0;
    accept  = 1'b0;
    data_in = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          owner_d = pick_idx;
          burst_d = '0;
        end
      end
      XFER: begin
        grant[owner_q] = ~fifo_full;
        accept         = ~fifo_full & req[owner_q];
        data_in        = word[owner_q];
        if (accept) begin
          burst_d = burst_q + 1'b1;
          count_d = count_q + 1'b1;
        end
        // Abandon, explicit last word, or burst cap: any of them ends ownership.
        if (!req[owner_q] ||
            (accept && (req_last[owner_q] || burst_q == BURST_END))) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset drops any burst in progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      burst_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      count_q <= count_d;
    end
  end

  assign write_en = accept;
  assign busy     = (state_q == XFER);
  assign owner    = owner_q;
  assign wr_count = count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// checked every cycle against a burst-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 16;
  localparam int IW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   grant;
  logic           write_en;
  logic [W-1:0]   data_in;
  logic           busy;
  logic [IW-1:0]  owner;
  logic [CW-1:0]  wr_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .fifo_full (fifo_full),
    .grant     (grant),
    .write_en  (write_en),
    .data_in   (data_in),
    .busy      (busy),
    .owner     (owner),
    .wr_count  (wr_count)
  );

  // ---------------- producer state ----------------
  logic [W:0]   prod_q [N][$];   // {last, data} words still to be sent
  logic [W-1:0] exp_q  [N][$];   // scoreboard: words each producer must see written, in order
  logic [N-1:0] hold = '0;
  logic [N-1:0] dut_acc = '0;
  int           drop_pct = 0;
  int           full_pct = 0;
  logic         full_force = 1'b0;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  bit             m_busy = 0;
  int             m_owner = 0;
  int             m_last = N - 1;
  int             m_words = 0;
  logic [CW-1:0]  m_total = '0;

  // Observation logs for the directed scenarios.
  int           own_log[$];
  int           len_log[$];
  logic [W-1:0] wr_log[$];
  bit           prev_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: expected outputs from the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] e_grant;
    logic         e_we;
    logic [W-1:0] e_data;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0; m_total = '0;
    end
    e_grant = '0;
    e_we    = 1'b0;
    e_data  = '0;
    if (m_busy && !rst) begin
      if (!fifo_full) e_grant[m_owner] = 1'b1;
      e_we   = !fifo_full && req[m_owner];
      e_data = req_data[m_owner*W +: W];
    end
    chk("grant",    64'(grant),    64'(e_grant));
    chk("write_en", 64'(write_en), 64'(e_we));
    chk("data_in",  64'(data_in),  64'(e_data));
    chk("busy",     64'(busy),     64'(m_busy && !rst));
    chk("owner",    64'(owner),    64'(m_owner));
    chk("wr_count", 64'(wr_count), 64'(m_total));
    dut_acc = grant & req;
    if (rst) begin
      prev_busy = 0;
    end else begin
      if (busy && !prev_busy) begin
        own_log.push_back(int'(owner));
        len_log.push_back(0);
      end
      if (write_en) begin
        wr_log.push_back(data_in);
        if (len_log.size() > 0) len_log[len_log.size()-1]++;
        if (exp_q[owner].size() == 0) begin
          checks++; failures++;
          $display("FAIL stream: unexpected word %0h from producer %0d", data_in, owner);
        end else begin
          chk("stream", 64'(data_in), 64'(exp_q[owner].pop_front()));
        end
      end
      prev_busy = busy;
    end
  end

  // Model advance at the clock edge, from the rules of the arbiter.
  always @(posedge clk) begin
    bit took;
    int j;
    took = 0;
    j = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0; m_total = '0;
    end else if (!m_busy) begin
      for (int d = 1; d <= N; d++) begin
        j = (m_last + d) % N;
        if (!took && req[j]) begin
          took = 1; m_busy = 1; m_owner = j; m_words = 0;
        end
      end
    end else begin
      took = !fifo_full && req[m_owner];
      if (took) begin
        m_words++;
        m_total++;
      end
      if (!req[m_owner] || (took && (req_last[m_owner] || m_words == MB))) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    prod_q[i].push_back({l, d});
    exp_q[i].push_back(d);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (dut_acc[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
    dut_acc = '0;
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() > 0) begin
        req_data[i*W +: W] = prod_q[i][0][W-1:0];
        req_last[i]        = prod_q[i][0][W];
        req[i] = !hold[i] && !(drop_pct > 0 && int'($urandom_range(99)) < drop_pct);
      end else begin
        req[i]      = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    fifo_full = full_force || (full_pct > 0 && int'($urandom_range(99)) < full_pct);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (prod_q[i].size() > 0) return 1;
    return m_busy;
  endfunction

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while (pending() && k < max_cycles) begin
      cycle();
      k++;
    end
    chk("drain_timeout", 64'(pending()), 64'(0));
  endtask

  task automatic wait_len(input int n, input int max_cycles);
    int k;
    k = 0;
    while (!(len_log.size() > 0 && len_log[len_log.size()-1] == n) && k < max_cycles) begin
      cycle();
      k++;
    end
    chk("wait_len_timeout", 64'(k < max_cycles), 64'(1));
  endtask

  task automatic do_reset();
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    own_log.delete();
    len_log.delete();
    wr_log.delete();
  endtask

  task automatic random_traffic(input int n_cycles);
    int i;
    for (int c = 0; c < n_cycles; c++) begin
      if ($urandom_range(1) == 0) begin
        i = int'($urandom_range(N-1));
        if (prod_q[i].size() < 6) push(i, W'($urandom), $urandom_range(3) == 0);
      end
      cycle();
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int k;
    cycle();
    cycle();
    chk("rst_grant",    64'(grant),    64'(0));
    chk("rst_write_en", 64'(write_en), 64'(0));
    chk("rst_data_in",  64'(data_in),  64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_owner",    64'(owner),    64'(0));
    chk("rst_wr_count", 64'(wr_count), 64'(0));
    rst = 1'b0;

    // Single producer, three words ending with req_last.
    clear_logs();
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    drain(50);
    chk("single_nwords", 64'(wr_log.size()), 64'(3));
    chk("single_w0", 64'(wr_log[0]), 64'h01);
    chk("single_w1", 64'(wr_log[1]), 64'h02);
    chk("single_w2", 64'(wr_log[2]), 64'h03);
    chk("single_count", 64'(wr_count), 64'(3));
    chk("single_bursts", 64'(len_log.size()), 64'(1));

    // Burst cap: requester 2 alone with five words, no last marker.
    clear_logs();
    for (int d = 1; d <= 5; d++) push(2, W'(8'h80 + d), 1'b0);
    drain(50);
    chk("cap_nbursts", 64'(own_log.size()), 64'(2));
    chk("cap_owner0", 64'(own_log[0]), 64'(2));
    chk("cap_owner1", 64'(own_log[1]), 64'(2));
    chk("cap_len0", 64'(len_log[0]), 64'(4));
    chk("cap_len1", 64'(len_log[1]), 64'(1));
    chk("cap_count", 64'(wr_count), 64'(8));

    // Fairness: all four loaded continuously after a fresh reset.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++)
      for (int d = 0; d < 8; d++) push(i, W'((i << 5) | d), 1'b0);
    drain(200);
    for (int b = 0; b < 8; b++) begin
      chk("fair_owner", 64'(own_log[b]), 64'(b % N));
      chk("fair_len", 64'(len_log[b]), 64'(4));
    end
    chk("fair_count", 64'(wr_count), 64'(32));

    // Full stall for five cycles after the second word.
    clear_logs();
    for (int d = 0; d < 4; d++) push(1, W'(8'h40 + d), 1'b0);
    wait_len(2, 20);
    full_force = 1'b1;
    fifo_full  = 1'b1;
    repeat (5) cycle();
    chk("stall_nowrites", 64'(wr_log.size()), 64'(2));
    chk("stall_kept_owner", 64'(owner), 64'(1));
    full_force = 1'b0;
    fifo_full  = 1'b0;
    drain(50);
    chk("stall_nbursts", 64'(len_log.size()), 64'(1));
    chk("stall_len", 64'(len_log[0]), 64'(4));

    // Abandon: requester 3 drops req after two words, then returns.
    clear_logs();
    for (int d = 0; d < 4; d++) push(3, W'(8'hC0 + d), 1'b0);
    wait_len(2, 20);
    hold[3] = 1'b1;
    req[3]  = 1'b0;
    cycle();
    cycle();
    hold[3] = 1'b0;
    drain(50);
    chk("abandon_nbursts", 64'(len_log.size()), 64'(2));
    chk("abandon_len0", 64'(len_log[0]), 64'(2));
    chk("abandon_len1", 64'(len_log[1]), 64'(2));

    // Random traffic with drops and full back-pressure.
    clear_logs();
    drop_pct = 10;
    full_pct = 20;
    random_traffic(700);
    drop_pct = 0;
    full_pct = 0;
    drain(500);
    for (int i = 0; i < N; i++) chk("rand_leftover", 64'(exp_q[i].size()), 64'(0));

    // Reset mid-burst, then a tie between requesters 0 and 3.
    clear_logs();
    for (int d = 0; d < 6; d++) push(2, W'(8'hA0 + d), 1'b0);
    wait_len(2, 20);
    rst = 1'b1;
    #1;
    chk("mrst_grant",    64'(grant),    64'(0));
    chk("mrst_write_en", 64'(write_en), 64'(0));
    chk("mrst_busy",     64'(busy),     64'(0));
    chk("mrst_wr_count", 64'(wr_count), 64'(0));
    hold[2] = 1'b1;
    push(0, 8'h11, 1'b1);
    push(3, 8'h33, 1'b1);
    cycle();
    cycle();
    clear_logs();
    rst = 1'b0;
    k = 0;
    while (own_log.size() == 0 && k < 10) begin
      cycle();
      k++;
    end
    chk("tie_first_owner", 64'(own_log[0]), 64'(0));
    hold[2] = 1'b0;
    drain(100);
    chk("final_leftover", 64'(exp_q[2].size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded", $time);
    $fatal(1, "timeout");
  end

endmodule
